mem_bus_responder: RTL

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_responder_pkg.sv | 28 ++
 rtl/word_fifo.sv | 63 ++++++
 rtl/mem_bus_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_bus_responder_pkg.sv
// Shared constants for the memory-bus responder: register word addresses,
// STATUS bit positions, reset values and the address-decode select type.
package mem_bus_responder_pkg;

    localparam logic [29:0] WA_CYCLE  = 30'h0000_0400;  // byte 0x1000
    localparam logic [29:0] WA_CMP    = 30'h0000_0401;  // byte 0x1004
    localparam logic [29:0] WA_STATUS = 30'h0000_0402;  // byte 0x1008
    localparam logic [29:0] WA_TXPUSH = 30'h0000_0403;  // byte 0x100C

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_COUNT_LSB = 2;
    localparam int ST_COUNT_W   = 6;
    localparam int ST_TIMER     = 8;
    localparam int ST_OVERFLOW  = 9;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_CYCLE,
        SEL_CMP,
        SEL_STATUS,
        SEL_TXPUSH
    } sel_e;

endpackage

// File: rtl/word_fifo.sv
// Power-of-two word FIFO with occupancy count; the head word is presented
// from storage registers and reads as zero while the FIFO is empty.
module word_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // When full, a same-cycle pop frees the slot the push lands in.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mem_bus_responder.sv
// CPU data-memory responder: word RAM, free-running cycle counter with compare
// flag, STATUS register and a TX FIFO drained through a valid/ready port.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic        MemRW_in,
    output logic [31:0] Data_out,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        timer_flag
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram_q [RAM_WORDS];
    logic [31:0]       cycle_q, cycle_d;
    logic [31:0]       cmp_q, cmp_d;
    logic              timer_flag_q, timer_flag_d;
    logic              overflow_q, overflow_d;

    sel_e              sel;
    logic [29:0]       waddr;
    logic [RAM_AW-1:0] ram_idx;
    logic              bus_we, ram_we, status_we, push_req, pop, drop;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [31:0]       fifo_head;
    logic [31:0]       status_rd;
    logic              unused_addr_lsbs;

    assign waddr            = Addr_in[31:2];
    assign ram_idx          = Addr_in[RAM_AW+1:2];
    assign unused_addr_lsbs = ^Addr_in[1:0];

    always_comb begin
        sel = SEL_NONE;
        if      (waddr == WA_CYCLE)                sel = SEL_CYCLE;
        else if (waddr == WA_CMP)                  sel = SEL_CMP;
        else if (waddr == WA_STATUS)               sel = SEL_STATUS;
        else if (waddr == WA_TXPUSH)               sel = SEL_TXPUSH;
        else if (Addr_in[31:RAM_AW+2] == '0)       sel = SEL_RAM;
    end

    // Bus writes landing in a reset cycle are discarded everywhere.
    assign bus_we    = MemRW_in && !rst;
    assign ram_we    = bus_we && (sel == SEL_RAM);
    assign status_we = bus_we && (sel == SEL_STATUS);
    assign push_req  = bus_we && (sel == SEL_TXPUSH);
    assign pop       = out_valid && out_ready;
    assign drop      = push_req && fifo_full && !pop;

    always_comb begin
        status_rd                                = '0;
        status_rd[ST_FULL]                       = fifo_full;
        status_rd[ST_EMPTY]                      = fifo_empty;
        status_rd[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
        status_rd[ST_TIMER]                      = timer_flag_q;
        status_rd[ST_OVERFLOW]                   = overflow_q;
    end

    always_comb begin
        case (sel)
            SEL_RAM:    Data_out = ram_q[ram_idx];
            SEL_CYCLE:  Data_out = cycle_q;
            SEL_CMP:    Data_out = cmp_q;
            SEL_STATUS: Data_out = status_rd;
            default:    Data_out = '0;
        endcase
    end

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        cmp_d   = (bus_we && (sel == SEL_CMP)) ? Data_in : cmp_q;

        // Clear is applied before set so a coincident set wins.
        timer_flag_d = timer_flag_q;
        if (status_we && Data_in[ST_TIMER]) timer_flag_d = 1'b0;
        if (cycle_q == cmp_q)               timer_flag_d = 1'b1;

        overflow_d = overflow_q;
        if (status_we && Data_in[ST_OVERFLOW]) overflow_d = 1'b0;
        if (drop)                              overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q      <= '0;
            cmp_q        <= CMP_RESET;
            timer_flag_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cycle_q      <= cycle_d;
            cmp_q        <= cmp_d;
            timer_flag_q <= timer_flag_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_idx] <= Data_in;
    end

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (Data_in),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_head;
    assign timer_flag = timer_flag_q;

endmodule
